// File: rtl/sd1010_pattern_tx.sv
// Serial frame transmitter feeding the 1010 sequence detector: parallel words in over
// valid/ready, MSB-first bits out on dout. Define SD_TX_MARK_EN to build the pattern_mark output.
module sd1010_pattern_tx #(
    parameter int                 WIDTH      = 8,
    parameter int                 GAP_CYCLES = 0,
    parameter logic               IDLE_LEVEL = 1'b0,
    parameter int                 PAT_LEN    = 4,
    parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
`ifdef SD_TX_MARK_EN
    output logic             pattern_mark,
`endif
    output logic             frame_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (WIDTH < 2 || PAT_LEN < 2 || $bits(PATTERN) != PAT_LEN) begin : g_bad_cfg
        $error("sd1010_pattern_tx: illegal WIDTH/PAT_LEN/PATTERN");
    end

    state_t           state, state_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [GW-1:0]    gap_cnt, gap_cnt_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic             dout_nx, dout_valid_nx, frame_done_nx, busy_nx;
    logic             last_bit, accept;

    // bit_cnt holds the index of the bit currently on dout; 0 marks the LSB cycle
    always_comb begin
        last_bit      = (state == SHIFT) && (bit_cnt == '0);
        load_ready    = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
        accept        = load_valid & load_ready;
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        gap_cnt_nx    = gap_cnt;
        sreg_nx       = sreg;
        dout_nx       = IDLE_LEVEL;
        dout_valid_nx = 1'b0;
        frame_done_nx = 1'b0;
        if (accept) begin
            state_nx      = SHIFT;
            bit_cnt_nx    = BIT_LAST;
            sreg_nx       = {load_data[WIDTH-2:0], 1'b0};
            dout_nx       = load_data[WIDTH-1];
            dout_valid_nx = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (last_bit) begin
                        bit_cnt_nx = '0;
                        if (GAP_CYCLES > 0) begin
                            state_nx   = GAP;
                            gap_cnt_nx = GAP_LAST;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        bit_cnt_nx    = bit_cnt - BW'(1);
                        sreg_nx       = sreg << 1;
                        dout_nx       = sreg[WIDTH-1];
                        dout_valid_nx = 1'b1;
                        frame_done_nx = (bit_cnt == BW'(1));
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state_nx = IDLE;
                    end else begin
                        gap_cnt_nx = gap_cnt - GW'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            gap_cnt    <= gap_cnt_nx;
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            busy       <= busy_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Shift data carries no control meaning, so it is left out of reset
    always_ff @(posedge clk) begin
        sreg <= sreg_nx;
    end

`ifdef SD_TX_MARK_EN
    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] hist, hist_nx;
    logic [FW-1:0]      fill, fill_nx;
    logic               mark_nx;

    // Mark is registered, so it compares the upcoming line bit against the shifted history
    always_comb begin
        hist_nx = {hist[PAT_LEN-2:0], dout};
        fill_nx = (fill == FW'(PAT_LEN)) ? fill : fill + FW'(1);
        mark_nx = (fill_nx >= FW'(PAT_LEN - 1)) &&
                  ({hist_nx[PAT_LEN-2:0], dout_nx} == PATTERN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist         <= {PAT_LEN{IDLE_LEVEL}};
            fill         <= '0;
            pattern_mark <= 1'b0;
        end else begin
            hist         <= hist_nx;
            fill         <= fill_nx;
            pattern_mark <= mark_nx;
        end
    end
`endif

endmodule
